hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_md_timer.sv | 26 ++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned MD_LATENCY = 8;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned STALLCNT_W = 16;
    // Wide enough to hold MD_LATENCY
    localparam int unsigned MD_TIMER_W = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_WAIT    = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_md_timer.sv
// Multiply/divide busy timer: loads the unit latency on issue, counts down to 0 and holds.
module hazard_md_timer
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [MD_TIMER_W-1:0] timer_q;

    // Countdown register; load wins over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (load) begin
            timer_q <= MD_TIMER_W'(MD_LATENCY);
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    assign busy = (timer_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch redirect flushes.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic                  id_useRs,
    input  logic                  id_useRt,
    input  logic                  ex_memRead,
    input  logic [REG_W-1:0]      ex_rt,
    input  logic                  ex_redirect,
    input  logic                  id_mdStart,
    input  logic                  id_mdRead,
    output logic                  pcWrite,
    output logic                  ifidWrite,
    output logic                  ifidFlush,
    output logic                  idexFlush,
    output logic                  mdBusy,
    output logic [1:0]            state,
    output logic [STALLCNT_W-1:0] stallCycles
);

    state_e                state_q;
    logic [STALLCNT_W-1:0] stall_cnt_q;
    logic                  md_busy;
    logic                  load_use;
    logic                  load_use_eff;
    logic                  md_haz;
    logic                  stall;
    logic                  md_load;

    // Hazard detection and stall decision
    always_comb begin
        load_use = ex_memRead && (ex_rt != '0) &&
                   ((id_useRs && (id_rs == ex_rt)) || (id_useRt && (id_rt == ex_rt)));
        // The bubble went in on the detecting cycle; LOAD_STALL masks a repeat so the
        // load-use penalty is exactly one cycle even if ID/EX still shows the load.
        load_use_eff = load_use && (state_q != LOAD_STALL);
        md_haz       = md_busy && (id_mdStart || id_mdRead);
        stall        = !ex_redirect && (load_use_eff || md_haz);
        md_load      = !rst && id_mdStart && !ex_redirect && !stall;
    end

    // Pipeline enables and flushes, same cycle as the inputs
    always_comb begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        if (rst) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (ex_redirect) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (stall) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
        end
    end

    // Mult/div timer; a redirect does not clear it since the in-flight op is older
    hazard_md_timer u_md_timer (
        .clk  (clk),
        .rst  (rst),
        .load (md_load),
        .busy (md_busy)
    );

    // Stall FSM and saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {STALLCNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ex_redirect) begin
                state_q <= RUN;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (load_use_eff)  state_q <= LOAD_STALL;
                        else if (md_haz)   state_q <= MD_WAIT;
                    end
                    LOAD_STALL: state_q <= RUN;
                    MD_WAIT: begin
                        if (!md_busy) state_q <= RUN;
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign mdBusy      = md_busy;
    assign state       = state_q;
    assign stallCycles = stall_cnt_q;

endmodule
